// File: rtl/load_store_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | load_store_unit_if : core request/response and data-memory port bundle |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface load_store_unit_if;
  logic [3:0]  core_read;
  logic [2:0]  core_write;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic [31:0] load_data;
  logic        misalign_err;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busywait;

  // master: the LSU itself; slave: the surrounding core plus data memory
  modport master (
    input  core_read, core_write, core_addr, core_wdata, mem_rdata, mem_busywait,
    output core_stall, load_data, misalign_err, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport slave (
    output core_read, core_write, core_addr, core_wdata, mem_rdata, mem_busywait,
    input  core_stall, load_data, misalign_err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | load_store_unit : word-memory initiator with sub-word extract and RMW  |
// | Optional trap of misaligned accesses: LSU_MISALIGN_TRAP_EN. rev 1.0    |
// +------------------------------------------------------------------------+
module load_store_unit (
  input  logic              clk_i,
  input  logic              rst_ni,
  load_store_unit_if.master bus
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_RMW_READ = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] load_data_q, load_data_d;
  logic        mis_q, mis_d;

  logic        req_ld, req_st, req_valid, req_mis;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext, merged;

  assign req_ld    = bus.core_read[3];
  assign req_st    = bus.core_write[2];
  assign req_valid = req_ld ^ req_st;

`ifdef LSU_MISALIGN_TRAP_EN
  logic [1:0] req_sz;
  assign req_sz  = req_ld ? bus.core_read[1:0] : bus.core_write[1:0];
  assign req_mis = ((req_sz == 2'b01) && bus.core_addr[0]) ||
                   (req_sz[1] && (bus.core_addr[1:0] != 2'b00));
`else
  assign req_mis = 1'b0;
`endif

  // Lane selection ignores address bits below the access size
  always_comb begin
    lane_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (op_q[1:0])
      2'b00:   ld_ext = {{24{~op_q[2] & lane_b[7]}}, lane_b};
      2'b01:   ld_ext = {{16{~op_q[2] & lane_h[15]}}, lane_h};
      default: ld_ext = bus.mem_rdata;
    endcase
    merged = bus.mem_rdata;
    if (op_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    else         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      op_q        <= '0;
      wdata_q     <= '0;
      wbuf_q      <= '0;
      load_data_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      wbuf_q      <= wbuf_d;
      load_data_q <= load_data_d;
      mis_q       <= mis_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    wbuf_d      = wbuf_q;
    load_data_d = load_data_q;
    mis_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = bus.core_addr;
          wdata_d = bus.core_wdata[15:0];
          op_d    = req_ld ? bus.core_read[2:0] : {1'b0, bus.core_write[1:0]};
          if (req_mis) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
          end else if (req_ld) begin
            state_d = S_LOAD;
          end else if (bus.core_write[1]) begin
            state_d = S_WRITE;
            wbuf_d  = bus.core_wdata;
          end else begin
            state_d = S_RMW_READ;
          end
        end
      end
      S_LOAD: begin
        if (!bus.mem_busywait) begin
          load_data_d = ld_ext;
          state_d     = S_DONE;
        end
      end
      S_RMW_READ: begin
        if (!bus.mem_busywait) begin
          wbuf_d  = merged;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!bus.mem_busywait) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stall is gated by reset so every output reads 0 while reset is held
  always_comb begin
    bus.core_stall   = 1'b0;
    bus.mem_read     = 4'b0000;
    bus.mem_write    = 3'b000;
    bus.mem_addr     = {addr_q[31:2], 2'b00};
    bus.mem_wdata    = wbuf_q;
    bus.load_data    = load_data_q;
    bus.misalign_err = mis_q;
    case (state_q)
      S_IDLE:     bus.core_stall = rst_ni & req_valid;
      S_LOAD,
      S_RMW_READ: begin
        bus.core_stall = 1'b1;
        bus.mem_read   = 4'b1010;
      end
      S_WRITE: begin
        bus.core_stall = 1'b1;
        bus.mem_write  = 3'b110;
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_load_store_unit : directed self-checking bench for load_store_unit  |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_load_store_unit;
  logic clk;
  logic rst_n;
  logic busy;
  logic [31:0] mem [16];
  int checks;
  int failures;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, write commits on a ready write edge
  assign bus.mem_rdata    = mem[bus.mem_addr[5:2]];
  assign bus.mem_busywait = busy;
  always_ff @(posedge clk)
    if (bus.mem_write[2] && !busy) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.core_read  = 4'b0000;
    bus.core_write = 3'b000;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
  endtask

  // One complete access: drive at negedge, sample 1 ns later each cycle
  task automatic access(input string tag, input bit is_load, input logic [2:0] code,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int nbusy, input int exp_cyc, input bit chk_data,
                        input logic [31:0] exp_data, input bit exp_mis,
                        input int exp_rd, input int exp_wr);
    int n, rd, wr, left;
    @(negedge clk);
    bus.core_read  = is_load ? {1'b1, code} : 4'b0000;
    bus.core_write = is_load ? 3'b000 : {1'b1, code[1:0]};
    bus.core_addr  = addr;
    bus.core_wdata = wdata;
    busy = 1'b0;
    #1;
    n = 0; rd = 0; wr = 0; left = nbusy;
    chk({tag, "_stall_c0"}, {31'd0, bus.core_stall}, 32'd1);
    while (bus.core_stall === 1'b1 && n < 20) begin
      rd += int'(bus.mem_read[3]);
      wr += int'(bus.mem_write[2]);
      if (bus.mem_read[3] && bus.mem_write[2])
        chk({tag, "_rd_wr_excl"}, 32'd1, 32'd0);
      if (left > 0 && (bus.mem_read[3] || bus.mem_write[2])) begin
        busy = 1'b1;
        left--;
      end else begin
        busy = 1'b0;
      end
      @(negedge clk);
      #1;
      n++;
    end
    busy = 1'b0;
    chk({tag, "_cycles"}, n, exp_cyc);
    chk({tag, "_rd_cycles"}, rd, exp_rd);
    chk({tag, "_wr_cycles"}, wr, exp_wr);
    chk({tag, "_misalign"}, {31'd0, bus.misalign_err}, {31'd0, exp_mis});
    if (chk_data) chk({tag, "_data"}, bus.load_data, exp_data);
    if (exp_rd + exp_wr > 0) chk({tag, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    busy = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall",     {31'd0, bus.core_stall}, 32'd0);
    chk("rst_mem_read",  {28'd0, bus.mem_read}, 32'd0);
    chk("rst_mem_write", {29'd0, bus.mem_write}, 32'd0);
    chk("rst_load_data", bus.load_data, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SW then LW
    access("sw04", 1'b0, 3'b010, 32'h04, 32'h8899AABB, 0, 2, 1'b0, 32'h0, 1'b0, 0, 1);
    chk("sw04_mem", mem[1], 32'h8899AABB);
    access("lw04", 1'b1, 3'b010, 32'h04, 32'h0, 0, 2, 1'b1, 32'h8899AABB, 1'b0, 1, 0);

    access("sw08", 1'b0, 3'b010, 32'h08, 32'h11223344, 0, 2, 1'b0, 32'h0, 1'b0, 0, 1);

    // Reset in the WRITE cycle of an SB: no commit, everything cleared
    @(negedge clk);
    bus.core_write = 3'b100;
    bus.core_addr  = 32'h09;
    bus.core_wdata = 32'h000000F0;
    repeat (2) @(negedge clk);
    #1;
    chk("rmw_in_write",  {29'd0, bus.mem_write}, 32'h6);
    chk("rmw_wdata",     bus.mem_wdata, 32'h1122F044);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_write", {29'd0, bus.mem_write}, 32'd0);
    chk("mid_rst_mem_read",  {28'd0, bus.mem_read}, 32'd0);
    chk("mid_rst_stall",     {31'd0, bus.core_stall}, 32'd0);
    chk("mid_rst_mem_addr",  bus.mem_addr, 32'd0);
    chk("mid_rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_mem_kept", mem[2], 32'h11223344);

    // Sub-word stores and extending loads
    access("sb09", 1'b0, 3'b000, 32'h09, 32'h123456F0, 0, 3, 1'b0, 32'h0, 1'b0, 1, 1);
    chk("sb09_mem", mem[2], 32'h1122F044);
    access("lb09",  1'b1, 3'b000, 32'h09, 32'h0, 0, 2, 1'b1, 32'hFFFFFFF0, 1'b0, 1, 0);
    access("lbu09", 1'b1, 3'b100, 32'h09, 32'h0, 0, 2, 1'b1, 32'h000000F0, 1'b0, 1, 0);
    access("sw0c",  1'b0, 3'b010, 32'h0C, 32'h00000000, 0, 2, 1'b0, 32'h0, 1'b0, 0, 1);
    access("sh0e",  1'b0, 3'b001, 32'h0E, 32'hDEAD8001, 0, 3, 1'b0, 32'h0, 1'b0, 1, 1);
    chk("sh0e_mem", mem[3], 32'h80010000);
    access("lh0e",  1'b1, 3'b001, 32'h0E, 32'h0, 0, 2, 1'b1, 32'hFFFF8001, 1'b0, 1, 0);
    access("lhu0e", 1'b1, 3'b101, 32'h0E, 32'h0, 0, 2, 1'b1, 32'h00008001, 1'b0, 1, 0);

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    access("lw06", 1'b1, 3'b010, 32'h06, 32'h0, 0, 1, 1'b1, 32'h00008001, 1'b1, 0, 0);
`else
    access("lw06", 1'b1, 3'b010, 32'h06, 32'h0, 0, 2, 1'b1, 32'h8899AABB, 1'b0, 1, 0);
`endif

    // Busy memory stretches LOAD by three cycles
    access("lbu08", 1'b1, 3'b100, 32'h08, 32'h0, 0, 2, 1'b1, 32'h00000044, 1'b0, 1, 0);
    access("lw04_busy", 1'b1, 3'b010, 32'h04, 32'h0, 3, 5, 1'b1, 32'h8899AABB, 1'b0, 4, 0);

    // Simultaneous load and store request is ignored
    @(negedge clk);
    bus.core_read  = 4'b1010;
    bus.core_write = 3'b110;
    bus.core_addr  = 32'h04;
    bus.core_wdata = 32'hCAFEF00D;
    #1;
    chk("illegal_stall_c0", {31'd0, bus.core_stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("illegal_stall_c1", {31'd0, bus.core_stall}, 32'd0);
    chk("illegal_mem_read", {28'd0, bus.mem_read}, 32'd0);
    chk("illegal_mem_write", {29'd0, bus.mem_write}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("illegal_mem_kept", mem[1], 32'h8899AABB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
